// File: rtl/tt_um_leg_solver.sv
// Leg solver tile: y = sqrt(h^2 - x^2) via shift-add squaring and a restoring bit-serial root.
// Optional macro LEG_ROUND_EN selects round-to-nearest instead of floor for the result.
module tt_um_leg_solver #(
   parameter int W      = 8,
   parameter int SQ_CYC = W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic [7:0]   ui_in,
   input  logic [7:0]   uio_in,
   output logic [7:0]   uo_out,
   output logic [7:0]   uio_out,
   output logic [7:0]   uio_oe
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] SQ_LAST   = CW'(SQ_CYC - 1);
   localparam logic [CW-1:0] ROOT_LAST = CW'(W - 1);

   typedef enum logic [2:0] {IDLE, SQ_H, SQ_X, SUB, ROOT, FIN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [W-1:0]     h_reg, x_reg, h_w, x_w;
   logic [2*W-1:0]   acc, mcand, h_sq, d;
   logic [W-1:0]     mplier;
   logic [2*W:0]     rem;
   logic [W-1:0]     root;
   logic [W-1:0]     y_q;
   logic             done_q, busy_q, err_q;

   logic             load_h, load_x, start;
   logic [2*W-1:0]   acc_add;
   logic [2*W:0]     rem_sh, trial;
   logic             fits;
   logic             unused_uio;

   assign load_h = uio_in[0];
   assign load_x = uio_in[1];
   assign start  = uio_in[2];
   assign unused_uio = &{1'b0, uio_in[7:3]};

   // One shift-add step and one restoring-root step, evaluated every cycle.
   assign acc_add = acc + (mplier[0] ? mcand : '0);
   assign rem_sh  = {rem[2*W-2:0], d[2*W-1:2*W-2]};
   assign trial   = {{(W-1){1'b0}}, root, 2'b01};
   assign fits    = (rem_sh >= trial);

`ifdef LEG_ROUND_EN
   // (r+0.5)^2 = r^2 + r + 0.25, so round up exactly when rem > r.
   function automatic logic [W-1:0] round_leg(input logic [W-1:0] r, input logic [2*W:0] rm);
      logic [W-1:0] one;
      one = {{(W-1){1'b0}}, 1'b1};
      round_leg = (rm > {{(W+1){1'b0}}, r}) ? r + one : r;
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         h_reg  <= '0;
         x_reg  <= '0;
         h_w    <= '0;
         x_w    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         h_sq   <= '0;
         d      <= '0;
         rem    <= '0;
         root   <= '0;
         y_q    <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (load_h) h_reg <= ui_in;
               if (load_x) x_reg <= ui_in;
               if (start) begin
                  h_w    <= h_reg;
                  x_w    <= x_reg;
                  acc    <= '0;
                  mcand  <= {{W{1'b0}}, h_reg};
                  mplier <= h_reg;
                  cnt    <= '0;
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= SQ_H;
               end
            end
            SQ_H: begin
               if (cnt == SQ_LAST) begin
                  h_sq   <= acc_add;
                  acc    <= '0;
                  mcand  <= {{W{1'b0}}, x_w};
                  mplier <= x_w;
                  cnt    <= '0;
                  state  <= SQ_X;
               end else begin
                  acc    <= acc_add;
                  mcand  <= {mcand[2*W-2:0], 1'b0};
                  mplier <= {1'b0, mplier[W-1:1]};
                  cnt    <= cnt + 1'b1;
               end
            end
            SQ_X: begin
               acc    <= acc_add;
               mcand  <= {mcand[2*W-2:0], 1'b0};
               mplier <= {1'b0, mplier[W-1:1]};
               if (cnt == SQ_LAST) begin
                  cnt   <= '0;
                  state <= SUB;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SUB: begin
               // x > h has no real leg; feed zero through the root so timing is unchanged.
               if (x_w > h_w) begin
                  err_q <= 1'b1;
                  d     <= '0;
               end else begin
                  d <= h_sq - acc;
               end
               rem   <= '0;
               root  <= '0;
               cnt   <= '0;
               state <= ROOT;
            end
            ROOT: begin
               rem  <= fits ? rem_sh - trial : rem_sh;
               root <= {root[W-2:0], fits};
               d    <= {d[2*W-3:0], 2'b00};
               if (cnt == ROOT_LAST) begin
                  state <= FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIN: begin
`ifdef LEG_ROUND_EN
               y_q <= round_leg(root, rem);
`else
               y_q <= root;
`endif
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign uo_out  = y_q;
   assign uio_out = {done_q, busy_q, err_q, 5'b0_0000};
   assign uio_oe  = 8'b1110_0000;

endmodule
